axicb_wch_scheduler: RTL
========================

AXICB_WCH_SCHEDULER -- requirements
Module: axicb_wch_scheduler

Interface
REQ-001 SHALL have parameter MST_NB, default 4: number of masters; one-hot grant width.
REQ-002 SHALL have parameter DEPTH, default 8: outstanding AW grant entries; power of 2, at least 2.
REQ-003 SHALL have parameter TIMEOUT_ENABLE, default 1: when 1, enables the W-channel stall timer.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256: idle cycles before a timeout; at least 2.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock.
REQ-006 SHALL have port aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port aw_grant, input, MST_NB bits: one-hot grant from the AW arbiter.
REQ-008 SHALL have port aw_hs, input, 1 bit: AW handshake on the slave side (awvalid&awready).
REQ-009 SHALL have port aw_allow, output, 1 bit: 1 = AW handshake permitted; the switch ANDs it into awready.
REQ-010 SHALL have port w_hs, input, 1 bit: W handshake on the slave side.
REQ-011 SHALL have port w_last, input, 1 bit: wlast of the current beat.
REQ-012 SHALL have port w_sel, output, MST_NB bits: one-hot master that currently owns the W channel.
REQ-013 SHALL have port w_sel_valid, output, 1 bit: w_sel is meaningful.
REQ-014 SHALL have port outstanding, output, $clog2(DEPTH)+1 bits: number of queued bursts.
REQ-015 SHALL have port err_timeout, output, 1 bit: one-cycle pulse on a timeout.
REQ-016 SHALL have port err_len, output, 1 bit: one-cycle pulse when a burst reaches 256 beats without wlast.

Function
REQ-017 SHALL push aw_grant into a circular grant queue on every cycle where aw_hs=1 and aw_allow=1.
- Pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
- full = pointers equal except the wrap bit; empty = pointers fully equal.
REQ-018 SHALL drive aw_allow = ~full from registered state.
- Pop and push in the same cycle while full: the push is still blocked.
- aw_hs while aw_allow=0 is ignored.
REQ-019 SHALL drive w_sel = queue head and w_sel_valid = ~empty, both combinational from registers.
- Zero-cycle latency from an entry being queued to its grant appearing on w_sel.
REQ-020 SHALL run a state machine with three states.
- IDLE: empty.
- WAIT: head valid, no beat yet.
- BURST: at least one beat accepted.
REQ-021 SHALL use these transitions.
- IDLE->WAIT on push.
- WAIT->BURST on w_hs&~w_last.
- WAIT/BURST pop the head on w_hs&w_last, then go to WAIT if entries remain, else IDLE.
REQ-022 SHALL support simultaneous push and pop when not full: outstanding is unchanged and the new entry is queued behind the head.
REQ-023 SHALL keep an 8-bit beat counter: cleared on pop, incremented on w_hs&~w_last.
- w_hs&~w_last while the counter is 255: pulse err_len, pop the head, return to WAIT or IDLE.
REQ-024 SHALL, when TIMEOUT_ENABLE=1, count cycles in WAIT/BURST without w_hs.
- The timer clears on w_hs or on a state change.
- On reaching TIMEOUT_CYCLES-1: pulse err_timeout, pop the head, clear the beat counter, leave the timer cleared.
REQ-025 SHALL, when TIMEOUT_ENABLE=0, never assert err_timeout; the timer logic is removed.
REQ-026 SHALL give priority to w_last on a conflict: if a timeout or length error coincides with w_hs&w_last, perform a normal pop and raise no error pulse.
REQ-027 SHALL drive outstanding as write pointer minus read pointer, modulo 2*DEPTH.

Reset
REQ-028 SHALL clear pointers, beat counter, timer and state (IDLE) when aresetn=0 is sampled at a rising edge of aclk.
REQ-029 SHALL hold these outputs during and after reset: aw_allow=1, w_sel=0, w_sel_valid=0, outstanding=0, err_timeout=0, err_len=0.
REQ-030 SHALL discard all queued entries on reset mid-burst, with no error pulse.

Structure
REQ-031 SHALL place the state enum (IDLE/WAIT/BURST) and MAX_BEATS=256 in the shared axicb package.
REQ-032 SHALL implement the grant queue as an instance of axicb_scfifo (PASS_THRU=0, DATA_WIDTH=MST_NB, ADDR_WIDTH=$clog2(DEPTH)), fed with aresetn and with srst tied low.
REQ-033 SHALL keep the state machine, beat counter and timer local to this module.

Verification
REQ-034 SHALL cover: push 0b0010, then 4 W beats with last on beat 4 -> w_sel=0b0010 for 4 beats; outstanding 1->0; back to IDLE.
REQ-035 SHALL cover: 8 pushes with DEPTH=8 -> aw_allow=0 and outstanding=8; a 9th aw_hs is ignored; one pop -> aw_allow=1 the next cycle.
REQ-036 SHALL cover: full queue with aw_hs and a pop in the same cycle -> outstanding=7 and the pushed grant is absent.
REQ-037 SHALL cover: push, then no w_hs for 256 cycles -> err_timeout for one cycle; outstanding=0; state IDLE.
REQ-038 SHALL cover: 256 beats with w_last=0 -> err_len on the 256th beat; head popped.
REQ-039 SHALL cover: reset asserted in BURST with 3 entries queued -> next cycle outstanding=0, w_sel_valid=0, aw_allow=1.

Source files
------------

// File: rtl/axicb_pkg.sv
// Shared types and constants for the AXI crossbar write-channel logic.
// Holds the W-channel scheduler state encoding and the burst length limit.
package axicb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } wch_state_t;

    localparam int MAX_BEATS = 256;

endpackage

// File: rtl/axicb_scfifo.sv
// Single-clock FIFO with wrap-bit pointers and an occupancy count.
// PASS_THRU presents the input on the output while the FIFO is empty.
module axicb_scfifo #(
    parameter int PASS_THRU  = 0,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;

    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    always_ff @(posedge aclk) begin
        if (!aresetn || srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push && !full)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end

    assign data_out = (PASS_THRU != 0 && empty) ? data_in
                                                : mem[rd_ptr[ADDR_WIDTH-1:0]];

endmodule

// File: rtl/axicb_wch_scheduler.sv
// Orders W-channel ownership by AW grant order and retires bursts on
// wlast, on a 256-beat overrun, or on a stall timeout.
module axicb_wch_scheduler
    import axicb_pkg::*;
#(
    parameter int MST_NB         = 4,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_ENABLE = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [MST_NB-1:0]        aw_grant,
    input  logic                     aw_hs,
    output logic                     aw_allow,
    input  logic                     w_hs,
    input  logic                     w_last,
    output logic [MST_NB-1:0]        w_sel,
    output logic                     w_sel_valid,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_timeout,
    output logic                     err_len
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(MAX_BEATS);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    wch_state_t        state;
    wch_state_t        state_n;
    logic [BW-1:0]     beat_cnt;
    logic [MST_NB-1:0] head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              active;
    logic              pop_last;
    logic              len_hit;
    logic              timeout;
    logic              remain;

    axicb_scfifo #(
        .PASS_THRU  (0),
        .DATA_WIDTH (MST_NB),
        .ADDR_WIDTH (AW)
    ) u_queue (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (1'b0),
        .push     (push),
        .data_in  (aw_grant),
        .pop      (pop),
        .data_out (head),
        .full     (full),
        .empty    (empty),
        .count    (outstanding)
    );

    assign aw_allow    = ~full;
    assign push        = aw_hs & ~full;
    assign w_sel_valid = ~empty;
    assign w_sel       = empty ? '0 : head;

    // Reset gates all retire events so a mid-burst reset never pulses an error.
    assign active   = (state != IDLE) & aresetn;
    assign pop_last = active & w_hs & w_last;
    assign len_hit  = active & w_hs & ~w_last &
                      (beat_cnt == BW'(MAX_BEATS - 1));
    assign pop      = pop_last | len_hit | timeout;
    assign remain   = (outstanding > (AW+1)'(1)) | push;

    assign err_len     = len_hit;
    assign err_timeout = timeout;

    always_ff @(posedge aclk) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (push)
                    state_n = WAIT;
            end
            WAIT, BURST: begin
                if (pop)
                    state_n = remain ? WAIT : IDLE;
                else if (w_hs && !w_last)
                    state_n = BURST;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn || pop)
            beat_cnt <= '0;
        else if (active && w_hs && !w_last)
            beat_cnt <= beat_cnt + 1'b1;
    end

    if (TIMEOUT_ENABLE != 0) begin : g_timer
        logic [TW-1:0] timer;

        always_ff @(posedge aclk) begin
            if (!aresetn || !active || w_hs || pop || state_n != state)
                timer <= '0;
            else
                timer <= timer + 1'b1;
        end

        assign timeout = active & ~w_hs &
                         (timer == TW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timer
        assign timeout = 1'b0;
    end

endmodule
